// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: operation codes and controller states.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } op_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier: loads on start, then adds one partial product per edge.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic               running;

    // done and product are combinational so the top can capture the final sum on the last edge.
    always_comb begin
        done    = running && (cnt == LAST);
        product = acc + (mplier[0] ? mcand : '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            mcand   <= {{WIDTH{1'b0}}, a};
            mplier  <= b;
            acc     <= '0;
            cnt     <= '0;
            running <= 1'b1;
        end else if (running) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (done) begin
                cnt     <= '0;
                running <= 1'b0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops, iterative MUL. Handshake: start is taken
// only in IDLE on a rising edge; done pulses one cycle with Resultado and flags valid.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [2:0]         OP,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] Resultado,
    output logic               CarryOut,
    output logic               Overflow,
    output logic               Cero,
    output logic               Negativo,
    output logic               state_dbg
);
    state_t             state_q, state_d;
    op_t                op;
    logic               mul_start, mul_done, accept_alu;
    logic [2*WIDTH-1:0] mul_product;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   diff;
    logic [2*WIDTH-1:0] alu_res;
    logic               alu_c, alu_v;

    assign op        = op_t'(OP);
    assign state_dbg = state_q;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (start && op == OP_MUL) state_d = S_MUL;
            S_MUL:  if (mul_done)              state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q == S_MUL);
        mul_start  = (state_q == S_IDLE) && start && (op == OP_MUL);
        accept_alu = (state_q == S_IDLE) && start && (op != OP_MUL);
    end

    // Single-cycle datapath, evaluated straight off the inputs at the accepting edge.
    always_comb begin
        sum     = {1'b0, A} + {1'b0, B};
        diff    = A + ~B + WIDTH'(1);
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        unique case (op)
            OP_ADD: begin
                alu_res = {{(WIDTH-1){1'b0}}, sum};
                alu_c   = sum[WIDTH];
                alu_v   = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = {{WIDTH{1'b0}}, diff};
                alu_c   = (A < B);
                alu_v   = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND: alu_res = {{WIDTH{1'b0}}, A & B};
            OP_OR:  alu_res = {{WIDTH{1'b0}}, A | B};
            OP_XOR: alu_res = {{WIDTH{1'b0}}, A ^ B};
            OP_SHL: begin
                alu_res = {{WIDTH{1'b0}}, A[WIDTH-2:0], 1'b0};
                alu_c   = A[WIDTH-1];
            end
            OP_SHR: begin
                alu_res = {{WIDTH{1'b0}}, 1'b0, A[WIDTH-1:1]};
                alu_c   = A[0];
            end
            default: alu_res = '0;
        endcase
    end

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (A),
        .b       (B),
        .done    (mul_done),
        .product (mul_product)
    );

    // Outputs only move on a completing edge, so they hold steady across MUL iterations.
    always_ff @(posedge clk) begin
        if (reset) begin
            done      <= 1'b0;
            Resultado <= '0;
            CarryOut  <= 1'b0;
            Overflow  <= 1'b0;
            Cero      <= 1'b0;
            Negativo  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept_alu) begin
                done      <= 1'b1;
                Resultado <= alu_res;
                CarryOut  <= alu_c;
                Overflow  <= alu_v;
                Cero      <= (alu_res == '0);
                Negativo  <= alu_res[WIDTH-1];
            end else if (mul_done) begin
                done      <= 1'b1;
                Resultado <= mul_product;
                CarryOut  <= 1'b0;
                Overflow  <= 1'b0;
                Cero      <= (mul_product == '0);
                Negativo  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 4..32.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 Port: start  input  1  request; accepted only in IDLE.
REQ-005 Port: OP  input  3  operation code, latched on acceptance.
REQ-006 Port: A, B  input  WIDTH each  operands, latched on acceptance.
REQ-007 Port: busy  output  1  high while a MUL is iterating.
REQ-008 Port: done  output  1  one-cycle pulse; result and flags valid in that cycle.
REQ-009 Port: Resultado  output  2*WIDTH  registered result, held until next done or reset.
REQ-010 Port: CarryOut, Overflow, Cero, Negativo  output  1 each  registered flags, updated only with done.

Function
REQ-011 OP encoding SHALL be: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL.
REQ-012 States SHALL be IDLE, MUL; IDLE->MUL on accepted start with OP=MUL; MUL->IDLE after WIDTH iterations.
REQ-013 Acceptance: start=1 in IDLE on edge E0 latches A, B, OP; start outside IDLE is ignored, never queued.
REQ-014 Non-MUL ops SHALL write Resultado and flags at E0; done high in the following cycle (latency 1); state remains IDLE, so back-to-back starts are accepted every cycle.
REQ-015 ADD: Resultado = zero-extended WIDTH+1-bit A+B; CarryOut = bit WIDTH of sum; Overflow = signed two's-complement overflow.
REQ-016 SUB: low WIDTH bits = A + ~B + 1, upper bits zero; CarryOut = borrow (A < B unsigned); Overflow = signed overflow (operand signs differ and result sign differs from A).
REQ-017 AND/OR/XOR: bitwise on WIDTH bits, upper bits zero; CarryOut=0, Overflow=0.
REQ-018 SHL/SHR: shift A by one bit, zero fill; CarryOut = bit shifted out; Overflow=0; B ignored.
REQ-019 MUL: unsigned shift-add, one iteration per edge E1..E_WIDTH; Resultado and flags written at E_WIDTH; done high in the following cycle (latency WIDTH+1); CarryOut=0, Overflow=0.
REQ-020 busy SHALL be high exactly in cycles following E0 through E_WIDTH-1 (WIDTH cycles).
REQ-021 Cero = (new Resultado == 0) for every op.
REQ-022 Negativo = bit WIDTH-1 of result for ADD/SUB/AND/OR/XOR/SHL/SHR; 0 for MUL.
REQ-023 Resultado and flags SHALL NOT change during MUL iterations; previous values held until E_WIDTH.
REQ-024 done SHALL never be high for two consecutive cycles from a single accepted start.

Reset
REQ-025 reset=1 SHALL at the next edge force state IDLE, busy=0, done=0, Resultado=0, all flags=0, iteration counter=0.
REQ-026 reset during MUL SHALL abort the operation with no done pulse; reset has priority over start in the same cycle.
REQ-027 First start after reset deasserts SHALL be accepted normally.

Structure
REQ-028 Shared package alu_pkg SHALL hold the op enum (op_t) and state enum (state_t); WIDTH stays a module parameter.
REQ-029 Iterative multiplier SHALL be one sub-module alu_mul_seq (start, operands, done, 2*WIDTH product), instantiated once.
REQ-030 Iteration counter width SHALL be $clog2(WIDTH)+1.

Verification (WIDTH=8)
REQ-031 ADD A=200 B=100 -> next cycle done=1, Resultado=0x012C, CarryOut=1, Overflow=0, Cero=0.
REQ-032 SUB A=0x9C(-100) B=0x32(50) -> Resultado=0x006A, Overflow=1, CarryOut=0, Negativo=0.
REQ-033 AND A=0xF0 B=0x0F -> Resultado=0, Cero=1; then OR with same operands next cycle -> 0x00FF, Cero=0.
REQ-034 MUL A=255 B=255 -> busy=1 for 8 cycles, done 9 cycles after acceptance, Resultado=0xFE01; start pulsed mid-MUL is ignored.
REQ-035 MUL A=3 B=5 with reset asserted at 4th busy cycle -> no done, outputs 0 after that edge; start ADD 1+1 next cycle -> Resultado=2.
REQ-036 SHL A=0x81 -> Resultado=0x0002, CarryOut=1; SHR A=0x01 -> Resultado=0, CarryOut=1, Cero=1.
